// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between N_REQ requesters: one-hot grant, bus lock, in-order read return.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed priority (lowest index wins).
module mem_port_arbiter #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ-1:0]         req_lock,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_wren,
    output logic                     mem_rden,
    input  logic [DATA_W-1:0]        mem_q,
    output logic                     busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic                 lock_q;
    logic [IDX_W-1:0]     owner_q;
    logic [N_REQ-1:0]     grant_c;
    logic [IDX_W-1:0]     grant_idx_c;
    logic                 found_c;
    logic                 accept_c;
    logic                 sel_we_c;
    logic                 sel_lock_c;
    logic [ADDR_W-1:0]    sel_addr_c;
    logic [DATA_W-1:0]    sel_wdata_c;
    logic [MEM_LAT:0]     pipe_vld;
    logic [IDX_W-1:0]     pipe_id [MEM_LAT+1];
    logic [DATA_W-1:0]    rdata_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]     ptr_q;
`endif

    // Grant: lock owner only while locked, otherwise first valid requester from the search start
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found_c     = 1'b0;
        if (lock_q) begin
            grant_c[owner_q] = req_valid[owner_q];
            grant_idx_c      = owner_q;
        end else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            for (int unsigned k = 0; k < N_REQ; k++) begin
                int unsigned cand;
                cand = 32'(ptr_q) + k;
                if (cand >= N_REQ) cand = cand - N_REQ;
                if (!found_c && req_valid[IDX_W'(cand)]) begin
                    found_c                = 1'b1;
                    grant_c[IDX_W'(cand)]  = 1'b1;
                    grant_idx_c            = IDX_W'(cand);
                end
            end
`else
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (!found_c && req_valid[IDX_W'(k)]) begin
                    found_c            = 1'b1;
                    grant_c[IDX_W'(k)] = 1'b1;
                    grant_idx_c        = IDX_W'(k);
                end
            end
`endif
        end
    end

    assign req_ready = grant_c;
    assign accept_c  = |(grant_c & req_valid);

    // Mux the granted requester's payload
    always_comb begin
        sel_we_c    = 1'b0;
        sel_lock_c  = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_c[i]) begin
                sel_we_c    = req_we[i];
                sel_lock_c  = req_lock[i];
                sel_addr_c  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata_c = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Lock is taken on an arbitrated acceptance and dropped the cycle after the owner releases req_lock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
        end else if (lock_q) begin
            if (!req_lock[owner_q]) lock_q <= 1'b0;
        end else if (accept_c && sel_lock_c) begin
            lock_q  <= 1'b1;
            owner_q <= grant_idx_c;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (accept_c && !lock_q) begin
            ptr_q <= (32'(grant_idx_c) == N_REQ - 1) ? '0 : grant_idx_c + 1'b1;
        end
    end
`endif

    // Registered RAM port; enables are single-cycle pulses, addr/wdata hold when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
            mem_rden  <= 1'b0;
        end else begin
            mem_wren <= 1'b0;
            mem_rden <= 1'b0;
            if (accept_c) begin
                mem_addr <= sel_addr_c;
                if (sel_we_c) begin
                    mem_wren  <= 1'b1;
                    mem_wdata <= sel_wdata_c;
                end else begin
                    mem_rden  <= 1'b1;
                end
            end
        end
    end

    // Requester-ID pipe; the last stage lines up with valid mem_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int unsigned s = 0; s <= MEM_LAT; s++) pipe_id[s] <= '0;
            rdata_q  <= '0;
        end else begin
            pipe_vld   <= {pipe_vld[MEM_LAT-1:0], accept_c & ~sel_we_c};
            pipe_id[0] <= grant_idx_c;
            for (int unsigned s = 1; s <= MEM_LAT; s++) pipe_id[s] <= pipe_id[s-1];
            if (pipe_vld[MEM_LAT]) rdata_q <= mem_q;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (pipe_vld[MEM_LAT]) rsp_valid[pipe_id[MEM_LAT]] = 1'b1;
    end

    // Present mem_q in the response cycle, then hold it until the next response
    assign rsp_rdata = pipe_vld[MEM_LAT] ? mem_q : rdata_q;
    assign busy      = mem_wren | mem_rden | (|pipe_vld);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (N_REQ=2, DATA_W=16, ADDR_W=9, MEM_LAT=1).
// Honours MEM_ARB_ROUND_ROBIN_EN for the contention expectations.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_we, req_lock, req_ready, rsp_valid;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic [15:0] rsp_rdata, mem_wdata, mem_q;
    logic [8:0]  mem_addr;
    logic        mem_wren, mem_rden, busy;

    mem_port_arbiter #(.DATA_W(16), .ADDR_W(9), .N_REQ(2), .MEM_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rden(mem_rden), .mem_q(mem_q), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM model, read latency 1 from the rden cycle
    logic [15:0] ram [512];
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        if (mem_rden) mem_q <= ram[mem_addr];
    end

    typedef struct {
        int          cyc;
        logic        in_rst;
        logic [1:0]  rdy;
        logic        wr;
        logic        rd;
        logic        bsy;
        logic [8:0]  addr;
        logic [15:0] wdata;
    } port_exp_t;

    typedef struct {
        int          cyc;
        logic [1:0]  id;
        logic [15:0] data;
    } rsp_exp_t;

    port_exp_t pexp [1024];
    string     pname [1024];
    rsp_exp_t  rexp [256];
    int        p_wr = 0, r_wr = 0;
    logic      done = 1'b0;

    // Stimulus-side model state
    logic        pend_wr, pend_rd;
    logic [8:0]  pend_addr;
    logic [15:0] pend_wdata;
    logic [15:0] shadow [512];
    int          rd_busy_until;

    task automatic step(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                        input logic [8:0] a0, input logic [8:0] a1,
                        input logic [15:0] d0, input logic [15:0] d1,
                        input logic [1:0] rdy, input string nm);
        logic [8:0]  a;
        logic [15:0] d;
        req_valid = v; req_we = we; req_lock = lk;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        pexp[p_wr] = '{cyc: cyc, in_rst: 1'b0, rdy: rdy, wr: pend_wr, rd: pend_rd,
                       bsy: pend_wr | pend_rd | (cyc <= rd_busy_until),
                       addr: pend_addr, wdata: pend_wdata};
        pname[p_wr] = nm;
        p_wr++;
        pend_wr = 1'b0;
        pend_rd = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (v[i] && rdy[i]) begin
                a = (i == 0) ? a0 : a1;
                d = (i == 0) ? d0 : d1;
                pend_addr = a;
                if (we[i]) begin
                    pend_wr    = 1'b1;
                    pend_wdata = d;
                    shadow[a]  = d;
                end else begin
                    pend_rd = 1'b1;
                    rexp[r_wr] = '{cyc: cyc + 2, id: 2'(1 << i), data: shadow[a]};
                    r_wr++;
                    rd_busy_until = cyc + 2;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(2'b00, 2'b00, 2'b00, 9'h0, 9'h0, 16'h0, 16'h0, 2'b00, "idle");
    endtask

    task automatic reset_cycles(input int n);
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        for (int k = 0; k < n; k++) begin
            pexp[p_wr] = '{cyc: cyc, in_rst: 1'b1, rdy: 2'b00, wr: 1'b0, rd: 1'b0,
                           bsy: 1'b0, addr: 9'h0, wdata: 16'h0};
            pname[p_wr] = "reset";
            p_wr++;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        pend_wr = 1'b0; pend_rd = 1'b0; pend_addr = '0; pend_wdata = '0;
        rd_busy_until = -100;
    endtask

    initial begin : stim
        logic [1:0] cont_rdy;
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        pend_wr = 1'b0; pend_rd = 1'b0; pend_addr = '0; pend_wdata = '0;
        rd_busy_until = -100;
        for (int i = 0; i < 512; i++) shadow[i] = 16'h0;
        @(posedge clk); #1;
        reset_cycles(2);
        // Read in flight is discarded by reset
        step(2'b01, 2'b00, 2'b00, 9'h010, 9'h0, 16'h0, 16'h0, 2'b01, "mid-read grant");
        reset_cycles(2);
        idle(3);
        // Write then read back the same address on consecutive cycles
        step(2'b10, 2'b10, 2'b00, 9'h0, 9'h005, 16'h0, 16'hBEEF, 2'b10, "write grant");
        step(2'b10, 2'b00, 2'b00, 9'h0, 9'h005, 16'h0, 16'h0, 2'b10, "readback grant");
        idle(3);
        // Locked burst from requester 1 while requester 0 waits
        step(2'b10, 2'b10, 2'b10, 9'h0, 9'h000, 16'h0, 16'h1000, 2'b10, "lock first");
        for (int n = 1; n < 8; n++)
            step(2'b11, 2'b10, (n < 7) ? 2'b10 : 2'b00, 9'h005, 9'(n), 16'h0,
                 16'h1000 + 16'(n), 2'b10, "lock burst");
        step(2'b01, 2'b00, 2'b00, 9'h005, 9'h0, 16'h0, 16'h0, 2'b01, "after unlock");
        idle(3);
        // Interleaved reads from both requesters
        step(2'b01, 2'b00, 2'b00, 9'h001, 9'h0, 16'h0, 16'h0, 2'b01, "ilv read 0");
        step(2'b10, 2'b00, 2'b00, 9'h0, 9'h002, 16'h0, 16'h0, 2'b10, "ilv read 1");
        idle(4);
        // Continuous contention
        for (int n = 0; n < 4; n++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            cont_rdy = (n % 2 == 0) ? 2'b01 : 2'b10;
`else
            cont_rdy = 2'b01;
`endif
            step(2'b11, 2'b00, 2'b00, 9'h005, 9'h006, 16'h0, 16'h0, cont_rdy, "contention");
        end
        idle(4);
        done = 1'b1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    initial begin : monitor
        int          p_rd;
        int          r_rd;
        logic [15:0] last_data;
        p_rd = 0; r_rd = 0; last_data = '0;
        forever begin
            @(negedge clk);
            while (p_rd < p_wr && pexp[p_rd].cyc <= cyc) begin
                if (pexp[p_rd].in_rst) begin
                    chk("reset req_ready", 32'(req_ready), 0);
                    chk("reset mem_wren", 32'(mem_wren), 0);
                    chk("reset mem_rden", 32'(mem_rden), 0);
                    chk("reset mem_addr", 32'(mem_addr), 0);
                    chk("reset mem_wdata", 32'(mem_wdata), 0);
                    chk("reset rsp_valid", 32'(rsp_valid), 0);
                    chk("reset rsp_rdata", 32'(rsp_rdata), 0);
                    chk("reset busy", 32'(busy), 0);
                end else begin
                    chk({pname[p_rd], " req_ready"}, 32'(req_ready), 32'(pexp[p_rd].rdy));
                    chk({pname[p_rd], " mem_wren"}, 32'(mem_wren), 32'(pexp[p_rd].wr));
                    chk({pname[p_rd], " mem_rden"}, 32'(mem_rden), 32'(pexp[p_rd].rd));
                    chk({pname[p_rd], " mem_addr"}, 32'(mem_addr), 32'(pexp[p_rd].addr));
                    if (pexp[p_rd].wr)
                        chk({pname[p_rd], " mem_wdata"}, 32'(mem_wdata), 32'(pexp[p_rd].wdata));
                    chk({pname[p_rd], " busy"}, 32'(busy), 32'(pexp[p_rd].bsy));
                end
                p_rd++;
            end
            if (rst) begin
                r_rd = r_wr;
                last_data = '0;
            end else if (rsp_valid != 2'b00) begin
                if (r_rd == r_wr) begin
                    chk("unexpected rsp_valid", 32'(rsp_valid), 0);
                end else begin
                    chk("rsp cycle", cyc, rexp[r_rd].cyc);
                    chk("rsp_valid id", 32'(rsp_valid), 32'(rexp[r_rd].id));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(rexp[r_rd].data));
                    last_data = rexp[r_rd].data;
                    r_rd++;
                end
            end else begin
                if (r_rd < r_wr && rexp[r_rd].cyc <= cyc) begin
                    chk("rsp_valid due", 32'(rsp_valid), 32'(rexp[r_rd].id));
                    r_rd++;
                end
                chk("rsp_rdata hold", 32'(rsp_rdata), 32'(last_data));
            end
            if (done) begin
                chk("responses outstanding", 32'(r_wr - r_rd), 0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
            if (cyc > 3000) begin
                chk("run time limit", 32'(done), 1);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised arbiter that shares one single-port synchronous RAM (data or instruction memory) between N_REQ requesters, e.g. processor and external loader.
- Replaces ad-hoc OR-ing of write enables and data muxing with a one-hot grant, a valid/ready request handshake, and per-requester read-response routing.
- Adds bus locking for bulk loads and a configurable RAM read latency.
- Sits between requesters and the memory IP instance.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 9, RAM address width
- N_REQ, 2, number of requesters (2..8)
- MEM_LAT, 1, RAM read latency in cycles from registered rden to valid q (1..4)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  N_REQ  per-requester request valid
- req_we  in  N_REQ  1 = write, 0 = read
- req_lock  in  N_REQ  hold grant after the current transfer
- req_addr  in  N_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_REQ*DATA_W  flattened write data
- req_ready  out  N_REQ  one-hot grant; transfer accepted when valid&ready
- rsp_valid  out  N_REQ  read data valid for requester i
- rsp_rdata  out  DATA_W  read data, shared by all requesters
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_wren  out  1  RAM write enable
- mem_rden  out  1  RAM read enable
- mem_q  in  DATA_W  RAM read data
- busy  out  1  transfer or read in flight

Behaviour:
- Reset (async, active-high):
  - mem_addr, mem_wdata, mem_wren, mem_rden, rsp_valid, rsp_rdata, busy, lock owner and priority pointer all clear to 0.
  - Reads in flight are discarded; no rsp_valid is issued after reset for them.
- Handshake:
  - req_ready is combinational from req_valid, lock state and priority.
  - At most one req_ready bit is high per cycle. req_ready[i] high implies req_valid[i] high, except for the lock case below.
  - A requester holds addr/we/wdata stable while valid and not ready.
- Memory port:
  - Registered. A transfer accepted in cycle t drives mem_addr/mem_wdata/mem_wren or mem_rden in cycle t+1.
  - The enables are single-cycle pulses.
  - With no acceptance, mem_wren = mem_rden = 0; addr/wdata hold their last value.
- Read response:
  - A read accepted at t gives rsp_valid[i] = 1 for exactly one cycle at t+1+MEM_LAT, with rsp_rdata = mem_q sampled that cycle.
  - Requester IDs are tracked in a MEM_LAT+1-deep shift pipe, so back-to-back reads from mixed requesters return in issue order.
  - rsp_rdata holds its value between responses.
- Throughput: one transfer per cycle, no bubbles between back-to-back grants.
- Ordering: a write accepted at t followed by a read of the same address at t+1 returns the new data.
- Lock:
  - If requester i is accepted with req_lock[i] = 1, i becomes lock owner.
  - While the owner's req_lock stays 1, only i may be granted. req_ready[i] = req_valid[i]; all other ready bits are 0.
  - The lock clears in the cycle after the owner deasserts req_lock. Arbitration resumes that cycle.
  - A lock held with req_valid low idles the port.
- Arbitration: fixed priority by default, with lowest index winning (see optional feature).
- busy = 1 when any enable is registered this cycle or the response pipe is non-empty.
- Widths: address and data are passed through unmodified; no truncation.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration. After a grant to i, search starts at (i+1) mod N_REQ.
  - The pointer is updated only on acceptance, not by locked transfers.
- Not defined:
  - Fixed priority; requester 0 always wins.
  - No priority pointer register is built.

Test Plan:
(All cases use N_REQ=2, DATA_W=16, ADDR_W=9, MEM_LAT=1.)
- Reset mid-read: req 0 reads addr 0x010, rst asserted the next cycle -> all outputs 0, no rsp_valid after rst releases.
- Write/read back: req 1 writes 0xBEEF to 0x005 at t, reads 0x005 at t+1 -> mem_wren at t+1, mem_rden at t+2, rsp_valid[1] at t+3 with rsp_rdata = 0xBEEF.
- Contention, macro off: both valid for 4 cycles -> req_ready = 01 every cycle; req 1 is starved.
- Contention, MEM_ARB_ROUND_ROBIN_EN on: both valid continuously -> req_ready alternates 01, 10, 01, 10.
- Lock burst: req 1 writes 0x000..0x007 (data 0x1000+n) with lock high while req 0 is valid -> eight consecutive mem_wren pulses; req 0 ready only after req 1 drops lock.
- Interleaved reads: req 0 reads 0x001, req 1 reads 0x002 on consecutive cycles -> rsp_valid 01 then 10 on consecutive cycles, each with the correct data.
